// File: rtl/axil_mon_pkg.sv
// axil_mon_pkg
//   Shared definitions for the AXI4-lite protocol monitor: error bit
//   indices, the sticky error vector type and a lowest-set-bit helper
//   used to record the first error since the last clear.
package axil_mon_pkg;

  localparam int ERR_AW_UNSTABLE   = 0;
  localparam int ERR_W_UNSTABLE    = 1;
  localparam int ERR_AR_UNSTABLE   = 2;
  localparam int ERR_AW_TIMEOUT    = 3;
  localparam int ERR_W_TIMEOUT     = 4;
  localparam int ERR_AR_TIMEOUT    = 5;
  localparam int ERR_B_TIMEOUT     = 6;
  localparam int ERR_R_TIMEOUT     = 7;
  localparam int ERR_B_ORPHAN      = 8;
  localparam int ERR_R_ORPHAN      = 9;
  localparam int ERR_OUTST_OVF     = 10;
  localparam int ERR_RESP_UNSTABLE = 11;
  localparam int ERR_N             = 12;

  typedef logic [ERR_N-1:0] err_vec_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [3:0] lowest_set(input err_vec_t v);
    logic [3:0] idx;
    idx = '0;
    for (int i = ERR_N - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/axil_mon_chan.sv
// axil_mon_chan
//   Per-channel checker for one valid/ready channel: flags a payload or
//   valid change while the channel is stalled, and flags a stall that
//   lasts TIMEOUT cycles (once per stall).
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   valid_i        channel valid
//   ready_i        channel ready
//   payload_i      channel payload that must stay stable while stalled
//   unstable_o     combinational: stalled last cycle and valid dropped or
//                  payload changed this cycle
//   timeout_o      combinational: this edge takes the stall count to TIMEOUT
module axil_mon_chan #(
  parameter int PAY_W   = 1,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             ready_i,
  input  logic [PAY_W-1:0] payload_i,
  output logic             unstable_o,
  output logic             timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_M1  = CW'(TIMEOUT - 1);

  logic             stall;
  logic             hold_q, hold_d;
  logic [PAY_W-1:0] pay_q, pay_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign stall  = valid_i & ~ready_i;
  assign hold_d = stall;
  assign pay_d  = payload_i;

  // Saturating stall counter; any non-stall cycle restarts it.
  always_comb begin
    cnt_d = '0;
    if (stall) begin
      if (cnt_q == TO_VAL) cnt_d = cnt_q;
      else                 cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q <= 1'b0;
      pay_q  <= '0;
      cnt_q  <= '0;
    end else begin
      hold_q <= hold_d;
      pay_q  <= pay_d;
      cnt_q  <= cnt_d;
    end
  end

  // pay_q is the payload seen on the cycle that set hold_q.
  assign unstable_o = hold_q & (~valid_i | (payload_i != pay_q));
  assign timeout_o  = stall & (cnt_q == TO_M1);

endmodule

// File: rtl/axil_protocol_monitor.sv
// axil_protocol_monitor
//   Passive AXI4-lite protocol monitor. Samples all five channels, checks
//   handshake stability, stall timeouts, orphan responses and outstanding
//   depth, and reports violations in a sticky error vector with a
//   first-error index and an interrupt.
// Build option
//   AXIL_MON_STATS_EN  when defined, wr_cnt/rd_cnt/stall_cnt are saturating
//                      counters; otherwise the ports are tied to zero.
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   axi_aw*/w*/b*/ar*/r*           sampled AXI4-lite bus signals (inputs only)
//   err_clr                        clears err_vec and err_first_vld
//   err_vec                        sticky error bits (see axil_mon_pkg)
//   err_first, err_first_vld       first error index since last clear
//   err_irq                        registered OR of err_vec
//   wr_cnt, rd_cnt, stall_cnt      statistics (B handshakes, R handshakes,
//                                  cycles with any channel stalled)
module axil_protocol_monitor
  import axil_mon_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                axi_awvalid,
  input  logic                axi_awready,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [2:0]          axi_awprot,
  input  logic                axi_wvalid,
  input  logic                axi_wready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_bvalid,
  input  logic                axi_bready,
  input  logic                axi_arvalid,
  input  logic                axi_arready,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [2:0]          axi_arprot,
  input  logic                axi_rvalid,
  input  logic                axi_rready,
  input  logic [DATA_W-1:0]   axi_rdata,
  input  logic                err_clr,
  output err_vec_t            err_vec,
  output logic [3:0]          err_first,
  output logic                err_first_vld,
  output logic                err_irq,
  output logic [CNT_W-1:0]    wr_cnt,
  output logic [CNT_W-1:0]    rd_cnt,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);

  logic aw_unst, w_unst, ar_unst, b_unst, r_unst;
  logic aw_to, w_to, ar_to, b_to, r_to;

  axil_mon_chan #(.PAY_W(ADDR_W + 3), .TIMEOUT(TIMEOUT)) u_aw (
    .clk_i      (clk),
    .rst_i      (reset),
    .valid_i    (axi_awvalid),
    .ready_i    (axi_awready),
    .payload_i  ({axi_awprot, axi_awaddr}),
    .unstable_o (aw_unst),
    .timeout_o  (aw_to)
  );

  axil_mon_chan #(.PAY_W(DATA_W + DATA_W/8), .TIMEOUT(TIMEOUT)) u_w (
    .clk_i      (clk),
    .rst_i      (reset),
    .valid_i    (axi_wvalid),
    .ready_i    (axi_wready),
    .payload_i  ({axi_wstrb, axi_wdata}),
    .unstable_o (w_unst),
    .timeout_o  (w_to)
  );

  axil_mon_chan #(.PAY_W(ADDR_W + 3), .TIMEOUT(TIMEOUT)) u_ar (
    .clk_i      (clk),
    .rst_i      (reset),
    .valid_i    (axi_arvalid),
    .ready_i    (axi_arready),
    .payload_i  ({axi_arprot, axi_araddr}),
    .unstable_o (ar_unst),
    .timeout_o  (ar_to)
  );

  // B carries no monitored payload; only a dropped bvalid counts.
  axil_mon_chan #(.PAY_W(1), .TIMEOUT(TIMEOUT)) u_b (
    .clk_i      (clk),
    .rst_i      (reset),
    .valid_i    (axi_bvalid),
    .ready_i    (axi_bready),
    .payload_i  (1'b0),
    .unstable_o (b_unst),
    .timeout_o  (b_to)
  );

  axil_mon_chan #(.PAY_W(DATA_W), .TIMEOUT(TIMEOUT)) u_r (
    .clk_i      (clk),
    .rst_i      (reset),
    .valid_i    (axi_rvalid),
    .ready_i    (axi_rready),
    .payload_i  (axi_rdata),
    .unstable_o (r_unst),
    .timeout_o  (r_to)
  );

  logic aw_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = axi_awvalid & axi_awready;
  assign b_hs  = axi_bvalid  & axi_bready;
  assign ar_hs = axi_arvalid & axi_arready;
  assign r_hs  = axi_rvalid  & axi_rready;

  logic [OW-1:0] wr_outst_q, wr_outst_d;
  logic [OW-1:0] rd_outst_q, rd_outst_d;

  // Request and response in the same cycle cancel; the count floors at 0
  // on an orphan response and holds at MAX_OUTST on overflow.
  always_comb begin
    wr_outst_d = wr_outst_q;
    if (aw_hs && !b_hs && (wr_outst_q != OUTST_MAX))
      wr_outst_d = wr_outst_q + 1'b1;
    else if (b_hs && !aw_hs && (wr_outst_q != '0))
      wr_outst_d = wr_outst_q - 1'b1;

    rd_outst_d = rd_outst_q;
    if (ar_hs && !r_hs && (rd_outst_q != OUTST_MAX))
      rd_outst_d = rd_outst_q + 1'b1;
    else if (r_hs && !ar_hs && (rd_outst_q != '0))
      rd_outst_d = rd_outst_q - 1'b1;
  end

  err_vec_t new_err;

  always_comb begin
    new_err                    = '0;
    new_err[ERR_AW_UNSTABLE]   = aw_unst;
    new_err[ERR_W_UNSTABLE]    = w_unst;
    new_err[ERR_AR_UNSTABLE]   = ar_unst;
    new_err[ERR_AW_TIMEOUT]    = aw_to;
    new_err[ERR_W_TIMEOUT]     = w_to;
    new_err[ERR_AR_TIMEOUT]    = ar_to;
    new_err[ERR_B_TIMEOUT]     = b_to;
    new_err[ERR_R_TIMEOUT]     = r_to;
    new_err[ERR_B_ORPHAN]      = b_hs & (wr_outst_q == '0);
    new_err[ERR_R_ORPHAN]      = r_hs & (rd_outst_q == '0);
    new_err[ERR_OUTST_OVF]     = (aw_hs & (wr_outst_q == OUTST_MAX)) |
                                 (ar_hs & (rd_outst_q == OUTST_MAX));
    new_err[ERR_RESP_UNSTABLE] = b_unst | r_unst;
  end

  err_vec_t   err_vec_q, err_vec_d;
  logic [3:0] err_first_q, err_first_d;
  logic       err_first_vld_q, err_first_vld_d;
  logic       err_irq_q, err_irq_d;
  logic       first_vld_kept;

  // A new error in the clear cycle survives the clear and may become
  // the new first error.
  always_comb begin
    err_vec_d       = (err_vec_q & ~{ERR_N{err_clr}}) | new_err;
    first_vld_kept  = err_first_vld_q & ~err_clr;
    err_first_d     = err_clr ? 4'd0 : err_first_q;
    err_first_vld_d = first_vld_kept;
    if (!first_vld_kept && (new_err != '0)) begin
      err_first_d     = lowest_set(new_err);
      err_first_vld_d = 1'b1;
    end
    err_irq_d = |err_vec_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_outst_q      <= '0;
      rd_outst_q      <= '0;
      err_vec_q       <= '0;
      err_first_q     <= '0;
      err_first_vld_q <= 1'b0;
      err_irq_q       <= 1'b0;
    end else begin
      wr_outst_q      <= wr_outst_d;
      rd_outst_q      <= rd_outst_d;
      err_vec_q       <= err_vec_d;
      err_first_q     <= err_first_d;
      err_first_vld_q <= err_first_vld_d;
      err_irq_q       <= err_irq_d;
    end
  end

  assign err_vec       = err_vec_q;
  assign err_first     = err_first_q;
  assign err_first_vld = err_first_vld_q;
  assign err_irq       = err_irq_q;

`ifdef AXIL_MON_STATS_EN
  logic             any_stall;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign any_stall = (axi_awvalid & ~axi_awready) | (axi_wvalid & ~axi_wready) |
                     (axi_bvalid  & ~axi_bready)  | (axi_arvalid & ~axi_arready) |
                     (axi_rvalid  & ~axi_rready);

  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (b_hs && (wr_cnt_q != '1))         wr_cnt_d    = wr_cnt_q + 1'b1;
    if (r_hs && (rd_cnt_q != '1))         rd_cnt_d    = rd_cnt_q + 1'b1;
    if (any_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign wr_cnt    = wr_cnt_q;
  assign rd_cnt    = rd_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign wr_cnt    = '0;
  assign rd_cnt    = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_axil_protocol_monitor.sv
module tb_axil_protocol_monitor;

  localparam int TO = 16;
  localparam int MO = 4;

  typedef struct packed {
    logic        awv, awr;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wv, wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bv, br;
    logic        arv, arr;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rv, rr;
    logic [31:0] rdata;
    logic        clr;
  } bus_t;

  typedef struct {
    bus_t        in;
    logic [11:0] exp_vec;
    logic        fchk;
    logic [3:0]  exp_first;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, err_clr;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [11:0] err_vec;
  logic [3:0]  err_first;
  logic        err_first_vld, err_irq;
  logic [15:0] wr_cnt, rd_cnt, stall_cnt;

  always #5 clk = ~clk;

  axil_protocol_monitor #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .MAX_OUTST(MO), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr), .axi_awprot(awprot),
    .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
    .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr), .axi_arprot(arprot),
    .axi_rvalid(rvalid), .axi_rready(rready), .axi_rdata(rdata),
    .err_clr(err_clr),
    .err_vec(err_vec), .err_first(err_first), .err_first_vld(err_first_vld),
    .err_irq(err_irq), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .stall_cnt(stall_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works from the rules directly: a per-channel stall run length, the
  // previous cycle's stall flag and payload, and integer outstanding counts.
  int          m_run[5];
  logic        m_prev_stall[5];
  logic [63:0] m_prev_pay[5];
  int          m_wo, m_ro;
  logic [11:0] m_vec;
  logic [3:0]  m_first;
  logic        m_vld;
  int          m_wrc, m_rdc, m_stc;

  task automatic model_reset();
    for (int c = 0; c < 5; c++) begin
      m_run[c] = 0; m_prev_stall[c] = 1'b0; m_prev_pay[c] = '0;
    end
    m_wo = 0; m_ro = 0; m_vec = '0; m_first = '0; m_vld = 1'b0;
    m_wrc = 0; m_rdc = 0; m_stc = 0;
  endtask

  task automatic model_step(input bus_t b);
    logic        v[5], r[5], unst[5], tout[5];
    logic [63:0] pay[5];
    logic [11:0] ne;
    logic        awh, bh, arh, rh, any_st;
    v[0] = b.awv; r[0] = b.awr; pay[0] = {29'd0, b.awprot, b.awaddr};
    v[1] = b.wv;  r[1] = b.wr;  pay[1] = {28'd0, b.wstrb, b.wdata};
    v[2] = b.arv; r[2] = b.arr; pay[2] = {29'd0, b.arprot, b.araddr};
    v[3] = b.bv;  r[3] = b.br;  pay[3] = '0;
    v[4] = b.rv;  r[4] = b.rr;  pay[4] = {32'd0, b.rdata};
    any_st = 1'b0;
    for (int c = 0; c < 5; c++) begin
      unst[c] = m_prev_stall[c] && (!v[c] || pay[c] != m_prev_pay[c]);
      tout[c] = 1'b0;
      if (v[c] && !r[c]) begin
        m_run[c]++;
        any_st = 1'b1;
        if (m_run[c] == TO) tout[c] = 1'b1;
      end else begin
        m_run[c] = 0;
      end
    end
    awh = b.awv && b.awr; bh = b.bv && b.br;
    arh = b.arv && b.arr; rh = b.rv && b.rr;
    ne = '0;
    ne[0] = unst[0]; ne[1] = unst[1]; ne[2] = unst[2];
    for (int c = 0; c < 5; c++) ne[3 + c] = tout[c];
    ne[8]  = bh && (m_wo == 0);
    ne[9]  = rh && (m_ro == 0);
    ne[10] = (awh && m_wo == MO) || (arh && m_ro == MO);
    ne[11] = unst[3] || unst[4];
    m_wo = m_wo + int'(awh) - int'(bh);
    if (m_wo < 0) m_wo = 0;
    if (m_wo > MO) m_wo = MO;
    m_ro = m_ro + int'(arh) - int'(rh);
    if (m_ro < 0) m_ro = 0;
    if (m_ro > MO) m_ro = MO;
    if (b.clr) begin m_vec = '0; m_vld = 1'b0; end
    m_vec = m_vec | ne;
    if (!m_vld && ne != 0) begin
      for (int i = 11; i >= 0; i--) if (ne[i]) m_first = 4'(i);
      m_vld = 1'b1;
    end
`ifdef AXIL_MON_STATS_EN
    if (bh && m_wrc < 65535) m_wrc++;
    if (rh && m_rdc < 65535) m_rdc++;
    if (any_st && m_stc < 65535) m_stc++;
`endif
    for (int c = 0; c < 5; c++) begin
      m_prev_stall[c] = v[c] && !r[c];
      m_prev_pay[c]   = pay[c];
    end
  endtask

  task automatic check_model();
    chk("model.err_vec", 64'(err_vec), 64'(m_vec));
    chk("model.err_first_vld", 64'(err_first_vld), 64'(m_vld));
    if (m_vld) chk("model.err_first", 64'(err_first), 64'(m_first));
    chk("model.err_irq", 64'(err_irq), 64'(|m_vec));
    chk("model.wr_cnt", 64'(wr_cnt), 64'(m_wrc));
    chk("model.rd_cnt", 64'(rd_cnt), 64'(m_rdc));
    chk("model.stall_cnt", 64'(stall_cnt), 64'(m_stc));
  endtask

  // ---------------- drive helpers ----------------
  task automatic apply(input bus_t b);
    awvalid = b.awv; awready = b.awr; awaddr = b.awaddr; awprot = b.awprot;
    wvalid  = b.wv;  wready  = b.wr;  wdata  = b.wdata;  wstrb  = b.wstrb;
    bvalid  = b.bv;  bready  = b.br;
    arvalid = b.arv; arready = b.arr; araddr = b.araddr; arprot = b.arprot;
    rvalid  = b.rv;  rready  = b.rr;  rdata  = b.rdata;
    err_clr = b.clr;
  endtask

  task automatic step(input bus_t b);
    apply(b);
    model_step(b);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".err_vec"}, 64'(err_vec), 64'd0);
    chk({nm, ".err_first"}, 64'(err_first), 64'd0);
    chk({nm, ".err_first_vld"}, 64'(err_first_vld), 64'd0);
    chk({nm, ".err_irq"}, 64'(err_irq), 64'd0);
    chk({nm, ".wr_cnt"}, 64'(wr_cnt), 64'd0);
    chk({nm, ".rd_cnt"}, 64'(rd_cnt), 64'd0);
    chk({nm, ".stall_cnt"}, 64'(stall_cnt), 64'd0);
  endtask

  // Asserts reset between edges with the current bus left as is.
  task automatic do_reset(input string nm);
    reset = 1'b1;
    #2;
    chk_all_zero(nm);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t tbl[$];

  function automatic void add(input bus_t b, input logic [11:0] ev,
                              input logic fchk = 1'b0, input logic [3:0] ef = 4'd0);
    vec_t t;
    t.in = b; t.exp_vec = ev; t.fchk = fchk; t.exp_first = ef;
    tbl.push_back(t);
  endfunction

  task automatic run_tbl(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].in);
      chk($sformatf("%s[%0d].err_vec", nm, i), 64'(err_vec), 64'(tbl[i].exp_vec));
      chk($sformatf("%s[%0d].err_irq", nm, i), 64'(err_irq), 64'(tbl[i].exp_vec != 0));
      if (tbl[i].fchk) begin
        chk($sformatf("%s[%0d].err_first", nm, i), 64'(err_first), 64'(tbl[i].exp_first));
        chk($sformatf("%s[%0d].err_first_vld", nm, i), 64'(err_first_vld), 64'd1);
      end
    end
    tbl.delete();
  endtask

  function automatic logic pick_valid(input logic pv, input logic pr);
    if (pv && !pr) return ($urandom_range(0, 99) < 97);
    return ($urandom_range(0, 99) < 60);
  endfunction

  function automatic logic pick_change(input logic pv, input logic pr);
    if (pv && !pr) return ($urandom_range(0, 99) < 5);
    return ($urandom_range(0, 99) < 50);
  endfunction

  function automatic bus_t rnd(input bus_t p, input int rp);
    bus_t b;
    b = p;
    b.awv = pick_valid(p.awv, p.awr); b.awr = ($urandom_range(0, 99) < rp);
    b.wv  = pick_valid(p.wv,  p.wr);  b.wr  = ($urandom_range(0, 99) < rp);
    b.bv  = pick_valid(p.bv,  p.br);  b.br  = ($urandom_range(0, 99) < rp);
    b.arv = pick_valid(p.arv, p.arr); b.arr = ($urandom_range(0, 99) < rp);
    b.rv  = pick_valid(p.rv,  p.rr);  b.rr  = ($urandom_range(0, 99) < rp);
    if (pick_change(p.awv, p.awr)) begin
      b.awaddr = $urandom & 32'hFF; b.awprot = 3'($urandom_range(0, 7));
    end
    if (pick_change(p.wv, p.wr)) begin
      b.wdata = $urandom; b.wstrb = 4'($urandom_range(0, 15));
    end
    if (pick_change(p.arv, p.arr)) begin
      b.araddr = $urandom & 32'hFF; b.arprot = 3'($urandom_range(0, 7));
    end
    if (pick_change(p.rv, p.rr)) b.rdata = $urandom;
    b.clr = ($urandom_range(0, 99) < 3);
    return b;
  endfunction

  bus_t b, idle;

  initial begin
    idle = '0;
    apply(idle);
    model_reset();
    #2;
    chk_all_zero("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Clean write: AW+W handshake, B two cycles later.
    b = idle; b.awv = 1; b.awr = 1; b.awaddr = 32'h40; b.wv = 1; b.wr = 1;
    b.wdata = 32'hDEADBEEF; b.wstrb = 4'hF;
    add(b, 12'h000);
    add(idle, 12'h000);
    b = idle; b.bv = 1; b.br = 1;
    add(b, 12'h000);
    run_tbl("clean_wr");
`ifdef AXIL_MON_STATS_EN
    chk("clean_wr.wr_cnt", 64'(wr_cnt), 64'd1);
`else
    chk("clean_wr.wr_cnt", 64'(wr_cnt), 64'd0);
`endif

    // AW address changes while stalled.
    do_reset("rst_aw_unst");
    b = idle; b.awv = 1; b.awaddr = 32'h100;
    add(b, 12'h000);
    b.awaddr = 32'h104;
    add(b, 12'h001, 1'b1, 4'd0);
    b.awr = 1;
    add(b, 12'h001, 1'b1, 4'd0);
    run_tbl("aw_unst");

    // AR stalled 20 cycles; clear after the timeout must not re-raise it.
    do_reset("rst_ar_to");
    b = idle; b.arv = 1; b.araddr = 32'h80;
    for (int i = 0; i < 20; i++) begin
      b.clr = (i == 16);
      add(b, (i >= 15 && i < 16) ? 12'h020 : 12'h000, (i == 15), 4'd5);
    end
    b.clr = 0; b.arr = 1;
    add(b, 12'h000);
    run_tbl("ar_timeout");

    // Orphan B, then one good write to show wr_outst floored at 0.
    do_reset("rst_b_orphan");
    b = idle; b.bv = 1; b.br = 1;
    add(b, 12'h100, 1'b1, 4'd8);
    b = idle; b.awv = 1; b.awr = 1;
    add(b, 12'h100);
    b = idle; b.bv = 1; b.br = 1;
    add(b, 12'h100, 1'b1, 4'd8);
    run_tbl("b_orphan");

    // Five ARs with MAX_OUTST=4, then four Rs clean, a fifth R orphaned.
    do_reset("rst_ovf");
    for (int i = 0; i < 5; i++) begin
      b = idle; b.arv = 1; b.arr = 1; b.araddr = 32'(i * 4);
      add(b, (i == 4) ? 12'h400 : 12'h000, (i == 4), 4'd10);
    end
    for (int i = 0; i < 5; i++) begin
      b = idle; b.rv = 1; b.rr = 1; b.rdata = 32'(i);
      add(b, (i == 4) ? 12'h600 : 12'h400, 1'b1, 4'd10);
    end
    run_tbl("outst_ovf");

    // Sticky bits, then clear coinciding with a new W_UNSTABLE.
    do_reset("rst_sticky");
    b = idle; b.awv = 1;
    add(b, 12'h000);
    add(idle, 12'h001, 1'b1, 4'd0);
    b = idle; b.bv = 1; b.br = 1;
    add(b, 12'h101, 1'b1, 4'd0);
    b = idle; b.wv = 1; b.wdata = 32'h55;
    add(b, 12'h101, 1'b1, 4'd0);
    b = idle; b.clr = 1;
    add(b, 12'h002, 1'b1, 4'd1);
    add(idle, 12'h002, 1'b1, 4'd1);
    run_tbl("clr_vs_set");

    // Reset in the middle of an AW stall.
    do_reset("rst_mid0");
    b = idle; b.awv = 1; b.awaddr = 32'h200;
    add(b, 12'h000);
    add(b, 12'h000);
    b.awaddr = 32'h204;
    add(b, 12'h001, 1'b1, 4'd0);
    run_tbl("mid_stall_a");
    do_reset("mid_stall_rst");
    b.awaddr = 32'h208;
    add(b, 12'h000);
    b.awaddr = 32'h20C;
    add(b, 12'h001, 1'b1, 4'd0);
    run_tbl("mid_stall_b");

    // Randomised traffic against the model at several ready densities.
    do_reset("rst_rand");
    b = idle;
    for (int seg = 0; seg < 3; seg++) begin
      int rp;
      rp = (seg == 0) ? 70 : (seg == 1) ? 30 : 6;
      for (int i = 0; i < 1500; i++) begin
        b = rnd(b, rp);
        step(b);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
